pwm_fade_multi: RTL and testbench

Parametrised multi-channel PWM generator with a shared, runtime-programmable period and a per-channel static or fade (breathing) mode. Each channel has a shadow configuration that loads only at period boundaries, so duty changes are glitch-free. The block sits between a register/config master and LED or actuator drivers, and replaces single-channel fixed-period PWM instances.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_channel.sv | 108 ++++++++++
 rtl/pwm_fade_multi.sv | 69 ++++++
 tb/tb_pwm_fade_multi.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
package pwm_pkg;

  localparam logic PWM_STATIC = 1'b0;
  localparam logic PWM_FADE   = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Channel index width; a single channel still needs a 1-bit address.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow config, active config, fade direction FSM and
// the registered duty compare.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          boundary,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] period,
  input  logic          we,
  input  logic          cfg_mode,
  input  logic [CW-1:0] cfg_duty,
  input  logic [CW-1:0] cfg_step,
  output logic          pwm_out
);

  logic          sh_mode_reg, sh_mode_next;
  logic [CW-1:0] sh_duty_reg, sh_duty_next;
  logic [CW-1:0] sh_step_reg, sh_step_next;
  logic          pending_reg, pending_next;
  logic          mode_reg, mode_next;
  logic [CW-1:0] duty_reg, duty_next;
  logic [CW-1:0] step_reg, step_next;
  dir_t          dir_reg, dir_next;
  logic          pwm_reg, pwm_next;
  logic [CW:0]   sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_mode_reg <= PWM_STATIC;
      sh_duty_reg <= '0;
      sh_step_reg <= '0;
      pending_reg <= 1'b0;
      mode_reg    <= PWM_STATIC;
      duty_reg    <= '0;
      step_reg    <= '0;
      dir_reg     <= DIR_UP;
      pwm_reg     <= 1'b0;
    end else begin
      sh_mode_reg <= sh_mode_next;
      sh_duty_reg <= sh_duty_next;
      sh_step_reg <= sh_step_next;
      pending_reg <= pending_next;
      mode_reg    <= mode_next;
      duty_reg    <= duty_next;
      step_reg    <= step_next;
      dir_reg     <= dir_next;
      pwm_reg     <= pwm_next;
    end
  end

  always_comb begin
    sh_mode_next = sh_mode_reg;
    sh_duty_next = sh_duty_reg;
    sh_step_next = sh_step_reg;
    pending_next = pending_reg;
    mode_next    = mode_reg;
    duty_next    = duty_reg;
    step_next    = step_reg;
    dir_next     = dir_reg;
    pwm_next     = pwm_reg;
    // One extra bit so duty+step never wraps before the period clamp.
    sum          = {1'b0, duty_reg} + {1'b0, step_reg};

    if (en) pwm_next = (cnt < duty_reg);

    if (boundary) begin
      if (pending_reg) begin
        mode_next    = sh_mode_reg;
        duty_next    = sh_duty_reg;
        step_next    = sh_step_reg;
        dir_next     = DIR_UP;
        pending_next = 1'b0;
      end else if (mode_reg == PWM_FADE && step_reg != '0) begin
        if (dir_reg == DIR_UP) begin
          if (sum >= {1'b0, period}) begin
            duty_next = period;
            dir_next  = DIR_DOWN;
          end else begin
            duty_next = sum[CW-1:0];
          end
        end else begin
          if (duty_reg <= step_reg) begin
            duty_next = '0;
            dir_next  = DIR_UP;
          end else begin
            duty_next = duty_reg - step_reg;
          end
        end
      end
    end

    // Written after the load so a write in the boundary cycle waits a period.
    if (we) begin
      sh_mode_next = cfg_mode;
      sh_duty_next = cfg_duty;
      sh_step_next = cfg_step;
      pending_next = 1'b1;
    end
  end

  assign pwm_out = pwm_reg;

endmodule

// File: rtl/pwm_fade_multi.sv
// Multi-channel PWM with a shared runtime period and per-channel
// static/fade modes; configs load glitch-free at period boundaries.
module pwm_fade_multi
  import pwm_pkg::*;
#(
  parameter int CH = 4,
  parameter int CW = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CW-1:0]             period,
  input  logic                      cfg_we,
  input  logic [ch_idx_w(CH)-1:0]   cfg_ch,
  input  logic                      cfg_mode,
  input  logic [CW-1:0]             cfg_duty,
  input  logic [CW-1:0]             cfg_step,
  output logic [CH-1:0]             pwm_out,
  output logic                      cycle_end
);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic          cycle_end_reg;
  logic          boundary;

  // ">=" rather than "==" so lowering period below cnt ends the period now.
  assign boundary = en && (cnt_reg >= period);

  always_comb begin
    cnt_next = cnt_reg;
    if (boundary)  cnt_next = '0;
    else if (en)   cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      cycle_end_reg <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      cycle_end_reg <= boundary;
    end
  end

  assign cycle_end = cycle_end_reg;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic we_ch;
      // Addresses at or above CH match no channel and are dropped.
      assign we_ch = cfg_we && (int'(cfg_ch) == gi);

      pwm_channel #(.CW(CW)) u_ch (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .boundary (boundary),
        .cnt      (cnt_reg),
        .period   (period),
        .we       (we_ch),
        .cfg_mode (cfg_mode),
        .cfg_duty (cfg_duty),
        .cfg_step (cfg_step),
        .pwm_out  (pwm_out[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pwm_fade_multi.sv
// Self-checking bench for pwm_fade_multi: cycle model, directed tables,
// hand-written corner sequences and randomized traffic.
module tb_pwm_fade_multi;
  localparam int CH = 5;
  localparam int CW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic [CW-1:0] period = 8'd9;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_ch = '0;
  logic          cfg_mode = 1'b0;
  logic [CW-1:0] cfg_duty = '0;
  logic [CW-1:0] cfg_step = '0;
  logic [CH-1:0] pwm_out;
  logic          cycle_end;

  int errors = 0;
  int checks = 0;

  pwm_fade_multi #(.CH(CH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .period(period),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_duty(cfg_duty), .cfg_step(cfg_step),
    .pwm_out(pwm_out), .cycle_end(cycle_end)
  );

  always #5 clk = ~clk;

  // Behavioural model state, derived from the rules of operation.
  int cnt_m;
  int duty_m[CH], step_m[CH], mode_m[CH], down_m[CH];
  int sh_duty[CH], sh_step[CH], sh_mode[CH], pend_m[CH];
  logic [CH-1:0] pwm_m;
  logic ce_m;

  task automatic model_update();
    bit bnd;
    if (rst) begin
      cnt_m = 0; pwm_m = '0; ce_m = 1'b0;
      for (int i = 0; i < CH; i++) begin
        duty_m[i] = 0; step_m[i] = 0; mode_m[i] = 0; down_m[i] = 0;
        sh_duty[i] = 0; sh_step[i] = 0; sh_mode[i] = 0; pend_m[i] = 0;
      end
    end else begin
      bnd = en && (cnt_m >= int'(period));
      if (en) for (int i = 0; i < CH; i++) pwm_m[i] = (cnt_m < duty_m[i]);
      ce_m = bnd;
      if (bnd) cnt_m = 0;
      else if (en) cnt_m = cnt_m + 1;
      for (int i = 0; i < CH; i++) begin
        if (bnd) begin
          if (pend_m[i] != 0) begin
            duty_m[i] = sh_duty[i]; step_m[i] = sh_step[i];
            mode_m[i] = sh_mode[i]; down_m[i] = 0; pend_m[i] = 0;
          end else if (mode_m[i] == 1 && step_m[i] > 0) begin
            if (down_m[i] == 0) begin
              if (duty_m[i] + step_m[i] >= int'(period)) begin
                duty_m[i] = int'(period); down_m[i] = 1;
              end else duty_m[i] = duty_m[i] + step_m[i];
            end else begin
              if (duty_m[i] <= step_m[i]) begin
                duty_m[i] = 0; down_m[i] = 0;
              end else duty_m[i] = duty_m[i] - step_m[i];
            end
          end
        end
      end
      if (cfg_we && int'(cfg_ch) < CH) begin
        sh_duty[cfg_ch] = int'(cfg_duty); sh_step[cfg_ch] = int'(cfg_step);
        sh_mode[cfg_ch] = int'(cfg_mode); pend_m[cfg_ch] = 1;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: advance the model, sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    checks++;
    if (pwm_out !== pwm_m || cycle_end !== ce_m) begin
      errors++;
      $display("FAIL cycle_model t=%0t: pwm_out=%b cycle_end=%b expected pwm_out=%b cycle_end=%b",
               $time, pwm_out, cycle_end, pwm_m, ce_m);
    end
  endtask

  task automatic wait_ce();
    int n = 0;
    do begin tick(); n++; end while (cycle_end !== 1'b1 && n < 600);
    if (cycle_end !== 1'b1) check("wait_cycle_end_timeout", 0, 1);
  endtask

  task automatic write_cfg(input int ch, input int mode, input int duty, input int step);
    cfg_ch = AW'(ch); cfg_mode = 1'(mode); cfg_duty = CW'(duty); cfg_step = CW'(step);
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  // Called right at a cycle_end sample; counts highs over one whole period.
  task automatic measure(input int ch, output int highs);
    highs = 0;
    for (int k = 0; k <= int'(period); k++) begin
      tick();
      if (pwm_out[ch]) highs++;
    end
  endtask

  typedef struct {
    int ch;
    int duty;
    int per;
    int exp_high;
  } vec_t;

  vec_t vecs[6];
  int fade_exp[8] = '{0, 4, 8, 9, 5, 1, 0, 4};

  initial begin
    int h, n;
    logic [CH-1:0] held;

    vecs[0] = '{0, 3, 9, 3};
    vecs[1] = '{0, 0, 9, 0};
    vecs[2] = '{2, 10, 9, 10};
    vecs[3] = '{3, 9, 9, 9};
    vecs[4] = '{4, 5, 4, 5};
    vecs[5] = '{1, 2, 4, 2};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_cycle_end", int'(cycle_end), 0);
    rst = 1'b0;

    // Static duty table
    foreach (vecs[v]) begin
      period = CW'(vecs[v].per);
      wait_ce();
      write_cfg(vecs[v].ch, 0, vecs[v].duty, 0);
      wait_ce();
      measure(vecs[v].ch, h);
      check($sformatf("static_highs[%0d]", v), h, vecs[v].exp_high);
    end

    // cycle_end period spacing at period=9
    period = 8'd9;
    wait_ce();
    n = 0;
    do begin tick(); n++; end while (cycle_end !== 1'b1 && n < 100);
    check("cycle_end_spacing", n, 10);

    // Write in the boundary cycle lands one period later
    write_cfg(0, 0, 3, 0);
    wait_ce();
    n = 0;
    while (cnt_m != int'(period) && n < 100) begin tick(); n++; end
    check("reach_boundary_cycle", cnt_m, int'(period));
    write_cfg(0, 0, 7, 0);
    check("boundary_write_cycle_end", int'(cycle_end), 1);
    measure(0, h);
    check("boundary_write_old_duty", h, 3);
    measure(0, h);
    check("boundary_write_new_duty", h, 7);

    // Out-of-range channel address
    write_cfg(5, 0, 1, 0);
    wait_ce();
    measure(0, h);
    check("ignored_addr_ch0", h, 7);
    measure(4, h);
    check("ignored_addr_ch4", h, 5);

    // en low mid-period stretches the period and freezes outputs
    wait_ce();
    tick(); tick(); tick();
    held = pwm_out;
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("en_low_pwm_held", int'(pwm_out), int'(held));
    end
    en = 1'b1;
    n = 8;
    do begin tick(); n++; end while (cycle_end !== 1'b1 && n < 100);
    check("en_low_stretched_period", n, 15);

    // Lowering period below cnt forces an immediate boundary
    period = 8'd20;
    wait_ce();
    n = 0;
    while (cnt_m != 12 && n < 100) begin tick(); n++; end
    check("reach_cnt_12", cnt_m, 12);
    period = 8'd5;
    tick();
    check("period_lower_cycle_end", int'(cycle_end), 1);

    // Fade triangle on ch1
    rst = 1'b1; tick(); rst = 1'b0;
    period = 8'd9;
    wait_ce();
    write_cfg(1, 1, 0, 4);
    wait_ce();
    for (int p = 0; p < 8; p++) begin
      measure(1, h);
      check($sformatf("fade_duty[%0d]", p), h, fade_exp[p]);
    end

    // Reset during fade at duty 8
    n = 0;
    while (duty_m[1] != 8 && n < 200) begin tick(); n++; end
    check("reach_fade_duty_8", duty_m[1], 8);
    tick(); tick(); tick();
    check("fade_pwm_high_before_rst", int'(pwm_out[1]), 1);
    rst = 1'b1;
    tick();
    check("rst_pwm_out", int'(pwm_out), 0);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      check("post_rst_low", int'(pwm_out), 0);
    end

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      rst      = ($urandom % 400) == 0;
      en       = ($urandom % 8) != 0;
      cfg_we   = ($urandom % 6) == 0;
      cfg_ch   = AW'($urandom % 8);
      cfg_mode = 1'($urandom % 2);
      cfg_duty = CW'($urandom % 20);
      cfg_step = CW'($urandom % 6);
      if (($urandom % 50) == 0) period = CW'($urandom_range(2, 15));
      tick();
    end
    rst = 1'b0; cfg_we = 1'b0; en = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
